// File: rtl/ark_engine.sv
// ark_engine: multi-cycle AES AddRoundKey, WPC words per cycle, selectable key byte layout
module ark_engine #(
  parameter int NR         = 10,
  parameter int WPC        = 1,
  parameter int KEY_LAYOUT = 0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:127]             state_in,
  input  logic [3:0]               round_idx,
  input  logic                     decrypt,
  input  logic [0:(NR+1)*128-1]    key_sched,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:127]             state_out,
  output logic                     err,
  output logic                     busy
);
  if (!(WPC == 1 || WPC == 2 || WPC == 4)) begin : g_bad_wpc
    $error("ark_engine: WPC must be 1, 2 or 4");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st_q;
  logic [1:0] w_q;
  logic [0:127] acc_q, key_q, acc_d, key_d, raw_key;
  logic bad_q, bad_d, last;
  logic [3:0] eff;
  // Out-of-range rounds select an all-zero key so the XOR pass leaves the state untouched
  always_comb begin
    bad_d = round_idx > 4'(NR);
    eff = decrypt ? 4'(NR) - round_idx : round_idx;
    raw_key = '0;
    key_d = '0;
    for (int r = 0; r <= NR; r++)
      if (!bad_d && eff == 4'(r)) raw_key = key_sched[128*r +: 128];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        key_d[8*(4*i+j) +: 8] = KEY_LAYOUT == 1 ? raw_key[8*(4*j+i) +: 8] :
                                KEY_LAYOUT == 2 ? raw_key[8*(4*(3-j)+i) +: 8] :
                                                  raw_key[8*(4*i+j) +: 8];
  end
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < WPC; k++)
      acc_d[32*(int'(w_q)+k) +: 32] = acc_q[32*(int'(w_q)+k) +: 32] ^ key_q[32*(int'(w_q)+k) +: 32];
  end
  assign last = w_q == 2'(4 - WPC);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_q      <= IDLE;
      w_q       <= '0;
      acc_q     <= '0;
      key_q     <= '0;
      bad_q     <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      state_out <= '0;
    end else begin
      case (st_q)
        IDLE: if (in_valid) begin
          st_q     <= RUN;
          acc_q    <= state_in;
          key_q    <= key_d;
          bad_q    <= bad_d;
          w_q      <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          acc_q <= acc_d;
          w_q   <= w_q + 2'(WPC);
          if (last) begin
            st_q      <= DONE;
            state_out <= acc_d;
            err       <= bad_q;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          st_q      <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ark_engine.sv
// tb_ark_engine: directed checks over five ark_engine configurations sharing one stimulus
module tb_ark_engine;
  logic Clk = 1'b0, Reset = 1'b1, in_valid = 1'b0, decrypt = 1'b0, out_ready = 1'b1;
  logic [3:0] round_idx = '0;
  logic [0:127] state_in = '0;
  logic [0:1407] key_sched = '0;
  logic ir[5], ov[5], er[5], bz[5];
  logic [0:127] so[5];
  int checks = 0, passes = 0;
  localparam logic [127:0] FIPS = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] LAY1 = 128'h0004080c0105090d02060a0e03070b0f;
  localparam logic [127:0] LAY2 = 128'h0c0804000d0905010e0a06020f0b0703;
  localparam logic [127:0] SIN  = 128'h0123456789abcdeffedcba9876543210;
  always #5 Clk = ~Clk;
  // instances: 0 WPC4, 1 WPC2, 2 WPC1 (direct); 3 layout 1, 4 layout 2 (both WPC4)
  for (genvar g = 0; g < 5; g++) begin : g_dut
    ark_engine #(
      .NR(10),
      .WPC(g == 1 ? 2 : g == 2 ? 1 : 4),
      .KEY_LAYOUT(g == 3 ? 1 : g == 4 ? 2 : 0)
    ) u_dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(ir[g]),
      .state_in(state_in), .round_idx(round_idx), .decrypt(decrypt),
      .key_sched(key_sched), .out_valid(ov[g]), .out_ready(out_ready),
      .state_out(so[g]), .err(er[g]), .busy(bz[g])
    );
  end
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask
  task automatic fill();
    for (int r = 0; r <= 10; r++) key_sched[128*r +: 128] = {16{8'(r)}};
  endtask
  initial begin
    step();
    step();
    check("rst_out_valid", ov[0], 0);
    check("rst_busy", bz[0], 0);
    check("rst_err", er[0], 0);
    check("rst_state_out", so[0], 0);
    Reset = 1'b0;
    step();
    check("rst_in_ready", ir[0], 1);
    fill();
    key_sched[0 +: 128] = 128'h000102030405060708090a0b0c0d0e0f;
    state_in = 128'h00112233445566778899aabbccddeeff;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("run_busy", bz[0], 1);
    check("run_in_ready", ir[0], 0);
    check("run_out_valid", ov[0], 0);
    step();
    check("w4_valid_c2", ov[0], 1);
    check("w4_state", so[0], FIPS);
    check("w4_err", er[0], 0);
    check("w2_not_yet", ov[1], 0);
    step();
    check("w2_valid_c3", ov[1], 1);
    check("w2_state", so[1], FIPS);
    check("w4_released", ov[0], 0);
    check("w4_ready_again", ir[0], 1);
    step();
    check("w1_not_yet", ov[2], 0);
    step();
    check("w1_valid_c5", ov[2], 1);
    check("w1_state", so[2], FIPS);
    repeat (2) step();
    state_in = '0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("lay1_valid", ov[3], 1);
    check("lay1_state", so[3], LAY1);
    check("lay2_state", so[4], LAY2);
    repeat (5) step();
    fill();
    decrypt = 1'b1;
    round_idx = 4'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    state_in = '1;
    key_sched = '1;
    round_idx = 4'd0;
    decrypt = 1'b0;
    step();
    check("dec_state", so[0], {16{8'h07}});
    check("dec_err", er[0], 0);
    repeat (5) step();
    check("dec_w1_held", so[2], {16{8'h07}});
    fill();
    state_in = SIN;
    round_idx = 4'd12;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("oor_valid", ov[0], 1);
    check("oor_err", er[0], 1);
    check("oor_state", so[0], SIN);
    repeat (5) step();
    check("oor_w1_err", er[2], 1);
    check("oor_w1_state", so[2], SIN);
    state_in = '0;
    round_idx = 4'd5;
    out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    step();
    check("bp_valid", ov[0], 1);
    for (int c = 0; c < 10; c++) begin
      step();
      check("bp_hold_valid", ov[0], 1);
      check("bp_hold_state", so[0], {16{8'h05}});
      check("bp_in_ready", ir[0], 0);
    end
    round_idx = 4'd1;
    out_ready = 1'b1;
    step();
    check("bp_released", ov[0], 0);
    check("bp_no_same_cycle", bz[0], 0);
    check("bp_ready_after", ir[0], 1);
    step();
    in_valid = 1'b0;
    check("bp_reaccept", bz[0], 1);
    step();
    check("bp_next_state", so[0], {16{8'h01}});
    repeat (5) step();
    round_idx = 4'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("abort_busy", bz[2], 0);
    check("abort_in_ready", ir[2], 1);
    check("abort_out_valid", ov[2], 0);
    check("abort_state", so[2], 0);
    for (int c = 0; c < 8; c++) begin
      step();
      check("abort_no_result", ov[2], 0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
